// File: rtl/seg_geom_pkg.sv
// ============================================================================
// seg_geom_pkg : VGA timing defaults and six-segment box geometry | rev 1.0
// ============================================================================
`default_nettype none

package seg_geom_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Upper quadrants span GEOM_ROW_TOP..GEOM_ROW_MID-1, lower ones GEOM_ROW_MID..GEOM_ROW_BOT.
  localparam int GEOM_ROW_TOP = 151;
  localparam int GEOM_ROW_MID = 226;
  localparam int GEOM_ROW_BOT = 300;

  localparam int NUM_SEG = 6;

  localparam logic [11:0] INK_RGB_DEF  = 12'hA00;
  localparam logic [11:0] BOX_RGB_DEF  = 12'h222;
  localparam logic [3:0]  MATCH_NIBBLE = INK_RGB_DEF[11:8];

  typedef struct packed {
    logic [9:0] l;
    logic [9:0] m;
    logic [9:0] r;
  } seg_cols_t;

  // Left half is l < h <= m, right half is m < h < r.
  function automatic seg_cols_t seg_cols(input int s);
    case (s)
      1:       return '{l: 10'd50,  m: 10'd87,  r: 10'd125};
      2:       return '{l: 10'd140, m: 10'd177, r: 10'd215};
      3:       return '{l: 10'd230, m: 10'd267, r: 10'd305};
      4:       return '{l: 10'd335, m: 10'd372, r: 10'd411};
      5:       return '{l: 10'd425, m: 10'd462, r: 10'd500};
      6:       return '{l: 10'd515, m: 10'd552, r: 10'd590};
      default: return '{l: 10'd0,   m: 10'd0,   r: 10'd0};
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_vga_timing.sv
// ============================================================================
// seg_vga_timing : pixel/line counters, syncs, video_on, frame_start | rev 1.0
// ============================================================================
`default_nettype none

module seg_vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] h_pos,
  output logic [9:0] v_pos,
  output logic       in_active,
  output logic       wrap,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       w_h_last;
  logic       w_v_last;

  assign w_h_last  = (r_h == H_LAST);
  assign w_v_last  = (r_v == V_LAST);
  assign wrap      = pix_en && w_h_last && w_v_last;
  assign in_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign h_pos     = r_h;
  assign v_pos     = r_v;

  // Outputs present the counter value of the previous strobe so they line up with pixel_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h         <= '0;
      r_v         <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (pix_en) begin
        r_h <= w_h_last ? '0 : r_h + 10'd1;
        if (w_h_last) begin
          r_v <= w_v_last ? '0 : r_v + 10'd1;
        end
        hcnt     <= r_h;
        vcnt     <= r_v;
        hsync    <= !((r_h >= H_SS) && (r_h < H_SE));
        vsync    <= !((r_v >= V_SS) && (r_v < V_SE));
        video_on <= in_active;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/segment_pattern_gen.sv
// ============================================================================
// segment_pattern_gen : VGA glyph source painting six dithered segment boxes | rev 1.0
// ============================================================================
`default_nettype none

module segment_pattern_gen
  import seg_geom_pkg::*;
#(
  parameter int          H_ACTIVE = H_ACTIVE_DEF,
  parameter int          H_FP     = H_FP_DEF,
  parameter int          H_SYNC   = H_SYNC_DEF,
  parameter int          H_BP     = H_BP_DEF,
  parameter int          V_ACTIVE = V_ACTIVE_DEF,
  parameter int          V_FP     = V_FP_DEF,
  parameter int          V_SYNC   = V_SYNC_DEF,
  parameter int          V_BP     = V_BP_DEF,
  parameter int          ROW_TOP  = GEOM_ROW_TOP,
  parameter int          ROW_MID  = GEOM_ROW_MID,
  parameter int          ROW_BOT  = GEOM_ROW_BOT,
  parameter logic [11:0] INK_RGB  = INK_RGB_DEF,
  parameter logic [11:0] BOX_RGB  = BOX_RGB_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        pat_valid,
  output logic        pat_ready,
  input  logic [2:0]  pat_seg,
  input  logic [15:0] pat_quads,
  output logic        pat_err,
  output logic [9:0]  hcnt,
  output logic [9:0]  vcnt,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] pixel_out,
  output logic        frame_start
);

  localparam logic [9:0] ROW_TOP_L = 10'(ROW_TOP);
  localparam logic [9:0] ROW_MID_L = 10'(ROW_MID);
  localparam logic [9:0] ROW_BOT_L = 10'(ROW_BOT);

  logic [15:0]        r_shadow [1:NUM_SEG];
  logic [15:0]        r_active [1:NUM_SEG];
  logic [9:0]         w_h;
  logic [9:0]         w_v;
  logic               w_vis;
  logic               w_wrap;
  logic               w_seg_ok;
  logic               w_rows;
  logic               w_lower;
  logic [NUM_SEG:1]   w_hit;
  logic [NUM_SEG:1]   w_right;
  logic               w_in_box;
  logic [3:0]         w_dens;
  logic               w_ink;

  seg_vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .h_pos       (w_h),
    .v_pos       (w_v),
    .in_active   (w_vis),
    .wrap        (w_wrap),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .frame_start (frame_start)
  );

  assign pat_ready = 1'b1;
  assign w_seg_ok  = (pat_seg != 3'd0) && (pat_seg != 3'd7);
  assign w_rows    = (w_v >= ROW_TOP_L) && (w_v <= ROW_BOT_L);
  assign w_lower   = (w_v >= ROW_MID_L);

  generate
    for (genvar s = 1; s <= NUM_SEG; s++) begin : g_seg
      localparam seg_cols_t C = seg_cols(s);
      assign w_hit[s]   = (w_h > C.l) && (w_h < C.r);
      assign w_right[s] = (w_h > C.m);
    end
  endgenerate

  // Quadrant nibble index is {lower, right}: q1=UL, q2=UR, q3=LL, q4=LR.
  always_comb begin
    w_in_box = 1'b0;
    w_dens   = 4'd0;
    for (int s = 1; s <= NUM_SEG; s++) begin
      if (w_hit[s]) begin
        w_in_box = 1'b1;
        w_dens   = r_active[s][{w_lower, w_right[s], 2'b00} +: 4];
      end
    end
  end

  assign w_ink = ({w_v[1:0], w_h[1:0]} < w_dens);

  // Commit and write share an edge: active takes the shadow value from before the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_out <= '0;
      pat_err   <= 1'b0;
      for (int s = 1; s <= NUM_SEG; s++) begin
        r_shadow[s] <= '0;
        r_active[s] <= '0;
      end
    end else begin
      pat_err <= pat_valid && !w_seg_ok;
      if (w_wrap) begin
        for (int s = 1; s <= NUM_SEG; s++) begin
          r_active[s] <= r_shadow[s];
        end
      end
      if (pat_valid && w_seg_ok) begin
        r_shadow[pat_seg] <= pat_quads;
      end
      if (pix_en) begin
        pixel_out <= (w_vis && w_rows && w_in_box) ? (w_ink ? INK_RGB : BOX_RGB) : 12'h000;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_segment_pattern_gen.sv
// ============================================================================
// tb_segment_pattern_gen : randomized bench with behavioural frame model | rev 1.0
// ============================================================================
`default_nettype none

module tb_segment_pattern_gen;

  // Short vertical timing and compressed rows keep a frame near 10k strobes.
  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 9, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int RT = 1, RM = 5, RB = 8;
  localparam logic [11:0] INK = 12'hA00;
  localparam logic [11:0] BOX = 12'h222;
  localparam int COL_L [0:5] = '{50, 140, 230, 335, 425, 515};
  localparam int COL_M [0:5] = '{87, 177, 267, 372, 462, 552};
  localparam int COL_R [0:5] = '{125, 215, 305, 411, 500, 590};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        pat_valid = 1'b0;
  logic [2:0]  pat_seg = 3'd0;
  logic [15:0] pat_quads = 16'h0;
  logic        pat_ready, pat_err, hsync, vsync, video_on, frame_start;
  logic [9:0]  hcnt, vcnt;
  logic [11:0] pixel_out;

  segment_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .ROW_TOP (RT), .ROW_MID (RM), .ROW_BOT (RB),
    .INK_RGB (INK), .BOX_RGB (BOX)
  ) dut (
    .clk (clk), .rst (rst), .pix_en (pix_en),
    .pat_valid (pat_valid), .pat_ready (pat_ready), .pat_seg (pat_seg),
    .pat_quads (pat_quads), .pat_err (pat_err),
    .hcnt (hcnt), .vcnt (vcnt), .hsync (hsync), .vsync (vsync),
    .video_on (video_on), .pixel_out (pixel_out), .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      if (n_fail >= 40) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_k = 0;
  int          m_p;
  logic [15:0] m_sh  [1:6];
  logic [15:0] m_act [1:6];
  logic [9:0]  e_h = '0, e_v = '0;
  logic        e_hs = 1'b1, e_vs = 1'b1, e_vo = 1'b0, e_fs = 1'b0, e_err = 1'b0;
  logic [11:0] e_pix = '0;
  logic        new_pix = 1'b0;

  function automatic logic [11:0] model_pix(input int h, input int v);
    logic [11:0] px;
    int q, d;
    px = 12'h000;
    if (h < HA && v < VA && v >= RT && v <= RB) begin
      for (int s = 0; s < 6; s++) begin
        if (h > COL_L[s] && h < COL_R[s]) begin
          q  = (v >= RM ? 2 : 0) + (h > COL_M[s] ? 1 : 0);
          d  = (int'(m_act[s+1]) >> (4 * q)) & 15;
          px = (((v % 4) * 4 + (h % 4)) < d) ? INK : BOX;
        end
      end
    end
    return px;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k = 0; e_h = '0; e_v = '0; e_hs = 1'b1; e_vs = 1'b1; e_vo = 1'b0;
      e_pix = '0; e_fs = 1'b0; e_err = 1'b0; new_pix = 1'b0;
      for (int s = 1; s <= 6; s++) begin
        m_sh[s] = '0;
        m_act[s] = '0;
      end
    end else begin
      new_pix = 1'b0;
      e_fs    = 1'b0;
      e_err   = pat_valid && (pat_seg == 3'd0 || pat_seg == 3'd7);
      if (pix_en) begin
        m_k++;
        m_p   = (m_k - 1) % FRAME;
        e_h   = 10'(m_p % HT);
        e_v   = 10'(m_p / HT);
        e_hs  = !((m_p % HT) >= HA + HF && (m_p % HT) < HA + HF + HS);
        e_vs  = !((m_p / HT) >= VA + VF && (m_p / HT) < VA + VF + VS);
        e_vo  = (m_p % HT) < HA && (m_p / HT) < VA;
        e_pix = model_pix(m_p % HT, m_p / HT);
        new_pix = 1'b1;
        if (m_k % FRAME == 0) begin
          e_fs = 1'b1;
          for (int s = 1; s <= 6; s++) m_act[s] = m_sh[s];
        end
      end
      if (pat_valid && pat_seg >= 3'd1 && pat_seg <= 3'd6) m_sh[pat_seg] = pat_quads;
    end
  end

  // ---------------- per-cycle compare and DUT-side counters ----------------
  int ink_total = 0, ink_s1q1 = 0, fs_cnt = 0, hs_low0 = 0, vs_low = 0;
  int ink_seg [0:5];
  int box_seg [0:5];

  task automatic clear_counts();
    ink_total = 0; ink_s1q1 = 0; fs_cnt = 0; hs_low0 = 0; vs_low = 0;
    for (int s = 0; s < 6; s++) begin
      ink_seg[s] = 0;
      box_seg[s] = 0;
    end
  endtask

  always @(posedge clk) begin
    #2;
    chk("timing", {24'd0, hcnt, vcnt, hsync, vsync, video_on, frame_start},
                  {24'd0, e_h, e_v, e_hs, e_vs, e_vo, e_fs});
    chk("pixel", {36'd0, pixel_out}, {36'd0, e_pix});
    chk("pat_flags", {46'd0, pat_err, pat_ready}, {46'd0, e_err, 1'b1});
    if (frame_start) fs_cnt++;
    if (new_pix) begin
      if (!hsync && vcnt == 10'd0) hs_low0++;
      if (!vsync) vs_low++;
      for (int s = 0; s < 6; s++) begin
        if (int'(hcnt) > COL_L[s] && int'(hcnt) < COL_R[s]) begin
          if (pixel_out == INK) ink_seg[s]++;
          if (pixel_out == BOX) box_seg[s]++;
        end
      end
      if (pixel_out == INK) begin
        ink_total++;
        if (hcnt > 10'd50 && hcnt <= 10'd87 && vcnt < 10'(RM)) ink_s1q1++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic pe, input logic v, input logic [2:0] s, input logic [15:0] q);
    pix_en = pe; pat_valid = v; pat_seg = s; pat_quads = q;
    @(negedge clk);
  endtask

  task automatic run_to_commit(input logic v, input logic [2:0] s, input logic [15:0] q);
    int g;
    g = 0;
    while (((m_k + 1) % FRAME) != 0) begin
      if (g > 2 * FRAME) begin
        n_chk++; n_fail++;
        $display("FAIL commit_timeout: got no commit, expected one within %0d cycles", 2 * FRAME);
        break;
      end
      cyc($urandom_range(0, 15) != 0, 1'b0, 3'd0, 16'h0);
      g++;
    end
    cyc(1'b1, v, s, q);
    chk("frame_start_pulse", {47'd0, frame_start}, 48'd1);
  endtask

  initial begin
    for (int s = 0; s < 6; s++) begin
      ink_seg[s] = 0;
      box_seg[s] = 0;
    end
    @(negedge clk); @(negedge clk);
    chk("reset_state", {16'd0, hcnt, vcnt, hsync, vsync, video_on, frame_start, pat_err, pixel_out},
                       {16'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000});
    rst = 1'b0;

    // Frame 1: load seg1, reject bad segment numbers.
    cyc(1'b1, 1'b1, 3'd1, 16'h8888);
    cyc(1'b1, 1'b1, 3'd0, 16'h1111);
    chk("pat_err_seg0", {47'd0, pat_err}, 48'd1);
    cyc(1'b1, 1'b1, 3'd7, 16'h2222);
    chk("pat_err_seg7", {47'd0, pat_err}, 48'd1);
    cyc(1'b1, 1'b0, 3'd0, 16'h0);
    chk("pat_err_clear", {47'd0, pat_err}, 48'd0);
    clear_counts();
    run_to_commit(1'b0, 3'd0, 16'h0);
    chk("f1_ink_total", 48'(ink_total), 48'd0);

    // Frame 2: seg1 visible; seg3 written twice back-to-back; seg2 written on the commit edge.
    clear_counts();
    cyc(1'b1, 1'b1, 3'd3, 16'h0000);
    cyc(1'b1, 1'b1, 3'd3, 16'hFFFF);
    chk("pat_err_b2b", {47'd0, pat_err}, 48'd0);
    run_to_commit(1'b1, 3'd2, 16'h4444);
    chk("f2_s1q1_ink", 48'(ink_s1q1), 48'd74);
    chk("f2_s1_ink", 48'(ink_seg[0]), 48'd296);
    chk("f2_ink_outside_s1", 48'(ink_total - ink_seg[0]), 48'd0);

    clear_counts();
    run_to_commit(1'b0, 3'd0, 16'h0);
    chk("f3_s3_ink", 48'(ink_seg[2]), 48'd554);
    chk("f3_s3_box", 48'(box_seg[2]), 48'd38);
    chk("f3_s2_old", 48'(ink_seg[1]), 48'd0);

    clear_counts();
    run_to_commit(1'b0, 3'd0, 16'h0);
    chk("f4_s2_new", 48'(ink_seg[1]), 48'd148);
    chk("f4_s3_ink", 48'(ink_seg[2]), 48'd554);

    // Mid-frame reset in the middle of the box rows.
    while ((m_k % FRAME) != 5 * HT + 100) cyc(1'b1, 1'b0, 3'd0, 16'h0);
    chk("pre_reset_pos", {28'd0, vcnt, hcnt}, {28'd0, 10'd5, 10'd99});
    rst = 1'b1;
    #1;
    chk("async_reset", {16'd0, hcnt, vcnt, hsync, vsync, video_on, frame_start, pat_err, pixel_out},
                       {16'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000});
    @(negedge clk);
    cyc(1'b1, 1'b1, 3'd4, 16'h1234);
    rst = 1'b0;
    clear_counts();

    // Randomized run: load all segments, then random strobes and writes over a full frame.
    for (int s = 1; s <= 6; s++) cyc(1'b1, 1'b1, 3'(s), 16'($urandom));
    while (m_k < FRAME - 1) begin
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
          3'($urandom_range(0, 7)), 16'($urandom));
    end
    chk("no_early_frame_start", 48'(fs_cnt), 48'd0);
    cyc(1'b1, 1'b0, 3'd0, 16'h0);
    chk("one_frame_start", 48'(fs_cnt), 48'd1);
    chk("hsync_low_line0", 48'(hs_low0), 48'd96);
    chk("vsync_low_frame", 48'(vs_low), 48'(2 * HT));
    while (m_k < FRAME + (RB + 1) * HT) begin
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
          3'($urandom_range(0, 7)), 16'($urandom));
    end
    cyc(1'b0, 1'b0, 3'd0, 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
